multiplicacao_acumulada: RTL and testbench

Parametrised successor to the 5x5 window × kernel element-wise multiplier used in the edge-detection datapath. It multiplies N_ELEM unsigned pixel values by N_ELEM signed kernel coefficients, LANES elements per clock. It returns every product, the signed sum of all products, and a saturated unsigned magnitude of that sum, ready for the gradient/threshold stage. Operands are captured at start, so upstream window registers may change while the block is busy.

---
 rtl/multiplicacao_acumulada_pkg.sv | 39 +++
 rtl/multiplicacao_acumulada_mult_lane.sv | 23 ++
 rtl/multiplicacao_acumulada.sv | 167 ++++++++++++++++
 tb/tb_multiplicacao_acumulada.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicacao_acumulada_pkg.sv
// Shared definitions for the windowed multiply-accumulate block:
// FSM encoding, width/beat derivations and the saturating magnitude helper.
package multiplicacao_acumulada_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working width of the magnitude helper; accumulators are sign-extended into it.
    localparam int MAG_CALC_W = 64;

    // Pixel is zero-extended by one bit, so the signed product needs a_w+b_w+1 bits.
    function automatic int calc_p_w(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    // Headroom for summing n_elem worst-case products without overflow.
    function automatic int calc_acc_w(input int p_w, input int n_elem);
        return p_w + $clog2(n_elem);
    endfunction

    // Number of clock beats needed to cover n_elem elements with 'lanes' multipliers.
    function automatic int calc_beats(input int n_elem, input int lanes);
        return (n_elem + lanes - 1) / lanes;
    endfunction

    // min(|v|, 2^out_w - 1); the most-negative input is handled by the wide working width.
    function automatic logic [MAG_CALC_W-1:0] sat_mag(input logic signed [MAG_CALC_W-1:0] v,
                                                      input int out_w);
        logic [MAG_CALC_W-1:0] a;
        logic [MAG_CALC_W-1:0] lim;
        a   = v[MAG_CALC_W-1] ? $unsigned(-v) : $unsigned(v);
        lim = (MAG_CALC_W'(1) << out_w) - MAG_CALC_W'(1);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/multiplicacao_acumulada_mult_lane.sv
// One multiplier lane: unsigned pixel times signed coefficient, full-width signed product.
module multiplicacao_acumulada_mult_lane #(
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int P_W = A_W + B_W + 1
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic signed [A_W:0]   a_ext;
    logic signed [B_W-1:0] b_s;
    logic signed [P_W-1:0] prod;

    // Extra zero MSB keeps the pixel positive once treated as signed.
    assign a_ext = {1'b0, a};
    assign b_s   = b;
    // Both operands sign-extended to the product width so nothing is truncated.
    assign prod  = P_W'(a_ext) * P_W'(b_s);
    assign p     = prod;

endmodule

// File: rtl/multiplicacao_acumulada.sv
// Window x kernel multiplier: LANES products per beat, signed running sum,
// saturated magnitude. Operands are captured on acceptance; outputs only
// change in the DONE cycle and hold in between operations.
module multiplicacao_acumulada
    import multiplicacao_acumulada_pkg::*;
#(
    parameter int N_ELEM = 25,
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int LANES  = 1,
    parameter int P_W    = calc_p_w(A_W, B_W),
    parameter int ACC_W  = calc_acc_w(P_W, N_ELEM),
    parameter int OUT_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [N_ELEM*A_W-1:0]   matrix_a,
    input  logic [N_ELEM*B_W-1:0]   matrix_b,
    output logic [N_ELEM*P_W-1:0]   result_out,
    output logic [ACC_W-1:0]        sum_out,
    output logic [OUT_W-1:0]        mag_out,
    output logic                    busy,
    output logic                    done
);

    localparam int BEATS = calc_beats(N_ELEM, LANES);
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [K_W-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [N_ELEM*A_W-1:0]      a_cap_q, a_cap_d;
    logic [N_ELEM*B_W-1:0]      b_cap_q, b_cap_d;
    logic [N_ELEM*P_W-1:0]      prod_q, prod_d;
    logic [N_ELEM*P_W-1:0]      result_q, result_d;
    logic [ACC_W-1:0]           sum_q, sum_d;
    logic [OUT_W-1:0]           mag_q, mag_d;

    logic [LANES-1:0][A_W-1:0]  lane_a;
    logic [LANES-1:0][B_W-1:0]  lane_b;
    logic [LANES-1:0][P_W-1:0]  lane_p;
    logic signed [ACC_W-1:0]    lane_sum;

    // Steer the current beat's elements to their lanes; idle lanes of a ragged beat see zero.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int e = 0; e < N_ELEM; e++) begin
            if (k_q == K_W'(e / LANES)) begin
                lane_a[e % LANES] = a_cap_q[e*A_W +: A_W];
                lane_b[e % LANES] = b_cap_q[e*B_W +: B_W];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        multiplicacao_acumulada_mult_lane #(
            .A_W (A_W),
            .B_W (B_W),
            .P_W (P_W)
        ) u_lane (
            .a (lane_a[j]),
            .b (lane_b[j]),
            .p (lane_p[j])
        );
    end

    // Sign-extended sum of this beat's lane products.
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + ACC_W'($signed(lane_p[j]));
        end
    end

    // Next-state and datapath updates for IDLE -> CALC (BEATS beats) -> DONE.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_cap_d  = a_cap_q;
        b_cap_d  = b_cap_q;
        prod_d   = prod_q;
        result_d = result_q;
        sum_d    = sum_q;
        mag_d    = mag_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    a_cap_d = matrix_a;
                    b_cap_d = matrix_b;
                    acc_d   = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + lane_sum;
                for (int e = 0; e < N_ELEM; e++) begin
                    if (k_q == K_W'(e / LANES)) begin
                        prod_d[e*P_W +: P_W] = lane_p[e % LANES];
                    end
                end
                if (k_q == K_W'(BEATS - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                result_d = prod_q;
                sum_d    = acc_q;
                mag_d    = OUT_W'(sat_mag(MAG_CALC_W'(acc_q), OUT_W));
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture, accumulator and output registers; reset discards any operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            k_q      <= '0;
            acc_q    <= '0;
            a_cap_q  <= '0;
            b_cap_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            sum_q    <= '0;
            mag_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_cap_q  <= a_cap_d;
            b_cap_q  <= b_cap_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            mag_q    <= mag_d;
        end
    end

    assign result_out = result_q;
    assign sum_out    = sum_q;
    assign mag_out    = mag_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_multiplicacao_acumulada.sv
// Bench: three instances (LANES = 1, 5, 4) share stimulus; a transaction-level
// model predicts every output each cycle, plus literal checks from the test plan.
module tb_multiplicacao_acumulada;

    localparam int N  = 25;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = AW + BW + 1;
    localparam int AC = PW + $clog2(N);
    localparam int OW = 8;
    localparam int NI = 3;
    localparam int RW = N * PW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic [N*AW-1:0] ma = '0;
    logic [N*BW-1:0] mb = '0;

    logic [RW-1:0] res [NI];
    logic [AC-1:0] sm  [NI];
    logic [OW-1:0] mg  [NI];
    logic          bz  [NI];
    logic          dn  [NI];

    int checks = 0;
    int fails  = 0;

    function automatic int lanes_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 5 : 4;
    endfunction
    function automatic int beats_of(input int g);
        return (N + lanes_of(g) - 1) / lanes_of(g);
    endfunction
    // Hand-derived latency (edges from acceptance to done visible) and done period.
    function automatic int lat_lit(input int g);
        return (g == 0) ? 26 : (g == 1) ? 6 : 8;
    endfunction
    function automatic int per_lit(input int g);
        return (g == 0) ? 27 : (g == 1) ? 7 : 9;
    endfunction

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        multiplicacao_acumulada #(
            .N_ELEM (N),
            .A_W    (AW),
            .B_W    (BW),
            .LANES  (lanes_of(g)),
            .OUT_W  (OW)
        ) u_dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .start      (start),
            .matrix_a   (ma),
            .matrix_b   (mb),
            .result_out (res[g]),
            .sum_out    (sm[g]),
            .mag_out    (mg[g]),
            .busy       (bz[g]),
            .done       (dn[g])
        );
    end

    task automatic chk(input string nm, input int g, input logic [RW-1:0] got, input logic [RW-1:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s lanes=%0d got=%h want=%h", nm, lanes_of(g), got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [RW-1:0] e_res [NI], p_res [NI];
    logic [AC-1:0] e_sum [NI], p_sum [NI];
    logic [OW-1:0] e_mag [NI], p_mag [NI];
    logic          e_busy[NI], e_done[NI];
    bit            act   [NI];
    int            cnt   [NI];

    task automatic reference(output logic [RW-1:0] r, output logic [AC-1:0] s, output logic [OW-1:0] m);
        int acc, p, av, bv, mgv;
        acc = 0;
        r   = '0;
        for (int e = 0; e < N; e++) begin
            av  = int'(ma[e*AW +: AW]);
            bv  = int'($signed(mb[e*BW +: BW]));
            p   = av * bv;
            r[e*PW +: PW] = p[PW-1:0];
            acc += p;
        end
        s   = acc[AC-1:0];
        mgv = (acc < 0) ? -acc : acc;
        if (mgv > (2**OW) - 1) mgv = (2**OW) - 1;
        m   = mgv[OW-1:0];
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        for (int g = 0; g < NI; g++) begin
            if (!reset_n) begin
                act[g] = 1'b0; cnt[g] = 0;
                e_res[g] = '0; e_sum[g] = '0; e_mag[g] = '0;
                e_busy[g] = 1'b0; e_done[g] = 1'b0;
            end else begin
                e_done[g] = 1'b0;
                if (act[g]) begin
                    cnt[g]++;
                    if (cnt[g] == beats_of(g) + 1) begin
                        e_res[g] = p_res[g]; e_sum[g] = p_sum[g]; e_mag[g] = p_mag[g];
                        e_done[g] = 1'b1; e_busy[g] = 1'b0; act[g] = 1'b0;
                    end
                end else if (start) begin
                    reference(p_res[g], p_sum[g], p_mag[g]);
                    act[g] = 1'b1; cnt[g] = 0; e_busy[g] = 1'b1;
                end
            end
        end
    end

    // Compare every output of every instance on each falling edge.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            for (int g = 0; g < NI; g++) begin
                chk("result_out", g, res[g], e_res[g]);
                chk("sum_out", g, RW'(sm[g]), RW'(e_sum[g]));
                chk("mag_out", g, RW'(mg[g]), RW'(e_mag[g]));
                chk("busy", g, RW'(bz[g]), RW'(e_busy[g]));
                chk("done", g, RW'(dn[g]), RW'(e_done[g]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_defaults();
        for (int e = 0; e < N; e++) begin
            ma[e*AW +: AW] = 8'd10;
            mb[e*BW +: BW] = (e == 12) ? 8'd24 : 8'hFF;
        end
    endtask

    task automatic load_extreme();
        for (int e = 0; e < N; e++) begin
            ma[e*AW +: AW] = 8'hFF;
            mb[e*BW +: BW] = 8'h80;
        end
    endtask

    task automatic load_random();
        for (int e = 0; e < N; e++) begin
            ma[e*AW +: AW] = ($urandom_range(0, 7) == 0) ? 8'hFF : AW'($urandom);
            mb[e*BW +: BW] = ($urandom_range(0, 7) == 0) ? 8'h80 : BW'($urandom);
        end
    endtask

    task automatic chk_el(input string nm, input int g, input int idx, input int want);
        logic [PW-1:0] w;
        w = want[PW-1:0];
        chk(nm, g, RW'(res[g][idx*PW +: PW]), RW'(w));
    endtask

    task automatic chk_sum(input string nm, input int g, input int want_sum, input int want_mag);
        logic [AC-1:0] ws;
        logic [OW-1:0] wm;
        ws = want_sum[AC-1:0];
        wm = want_mag[OW-1:0];
        chk({nm, "_sum"}, g, RW'(sm[g]), RW'(ws));
        chk({nm, "_mag"}, g, RW'(mg[g]), RW'(wm));
        chk({nm, "_model_sum"}, g, RW'(e_sum[g]), RW'(ws));
    endtask

    // One operation from idle; measures edges from acceptance to visible done.
    task automatic run_op();
        int lat [NI];
        int c;
        for (int g = 0; g < NI; g++) lat[g] = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        c = 1;
        while (c <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
            @(posedge clock); #1;
            for (int g = 0; g < NI; g++) if (dn[g] === 1'b1 && lat[g] == 0) lat[g] = c;
            c++;
        end
        for (int g = 0; g < NI; g++) chk("latency", g, RW'(lat[g]), RW'(lat_lit(g)));
        repeat (2) @(negedge clock);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nd [NI];
        int last [NI];
        int idx;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Defaults: centre 240, others -10, sum 0
        load_defaults();
        run_op();
        for (int g = 0; g < NI; g++) begin
            chk_el("t1_center", g, 12, 240);
            chk_el("t1_elem0", g, 0, -10);
            chk_el("t1_elem24", g, 24, -10);
            chk_sum("t1", g, 0, 0);
        end

        // Extreme operands: no truncation, saturation
        load_extreme();
        run_op();
        for (int g = 0; g < NI; g++) begin
            chk_el("t2_elem0", g, 0, -32640);
            chk_el("t2_elem24", g, 24, -32640);
            chk_sum("t2", g, -816000, 255);
        end

        // Operands and start changed mid-CALC: captured values win, single done
        load_defaults();
        for (int g = 0; g < NI; g++) nd[g] = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        load_random(); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int g = 0; g < NI; g++) if (dn[g] === 1'b1) nd[g]++;
        repeat (30) begin
            @(negedge clock);
            for (int g = 0; g < NI; g++) if (dn[g] === 1'b1) nd[g]++;
        end
        for (int g = 0; g < NI; g++) begin
            chk("t4_done_count", g, RW'(nd[g]), RW'(1));
            chk_el("t4_center", g, 12, 240);
            chk_sum("t4", g, 0, 0);
        end

        // Start held high: one done every BEATS+2 cycles
        for (int g = 0; g < NI; g++) last[g] = -1;
        idx = 0;
        @(negedge clock); start = 1'b1;
        repeat (90) begin
            @(negedge clock);
            idx++;
            load_random();
            for (int g = 0; g < NI; g++) begin
                if (dn[g] === 1'b1) begin
                    if (last[g] >= 0) chk("t4_period", g, RW'(idx - last[g]), RW'(per_lit(g)));
                    last[g] = idx;
                end
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clock);

        // Reset mid-operation, then a clean operation at nominal latency
        load_defaults();
        @(negedge clock); start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("t5_rst_result", g, res[g], '0);
            chk("t5_rst_sum", g, RW'(sm[g]), '0);
            chk("t5_rst_mag", g, RW'(mg[g]), '0);
            chk("t5_rst_busy", g, RW'(bz[g]), '0);
            chk("t5_rst_done", g, RW'(dn[g]), '0);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        load_extreme();
        run_op();
        for (int g = 0; g < NI; g++) begin
            chk_el("t5_elem7", g, 7, -32640);
            chk_sum("t5", g, -816000, 255);
        end

        // Hold: outputs stable, no done, for 50 idle cycles (model checks each cycle)
        load_random();
        repeat (50) @(negedge clock);
        for (int g = 0; g < NI; g++) chk_sum("t6", g, -816000, 255);

        // Random traffic
        repeat (400) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) == 0);
            load_random();
        end
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
